// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring counter decoder: FSM state type,
// rotate-left-by-one and a one-hot test on a zero-extended ring vector.
package ring_pkg;

  // Ring vectors are zero-extended to this width so the helpers work for any WIDTH up to it.
  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] ring_vec_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ring_state_t;

  // Rotate the low w bits left by one: bit i -> bit i+1, bit w-1 -> bit 0.
  function automatic ring_vec_t rotl1(input ring_vec_t v, input int w);
    ring_vec_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) begin
        r[0] = v[i];
      end else if (i < w - 1) begin
        r[i+1] = v[i];
      end
    end
    return r;
  endfunction

  function automatic logic is_onehot(input ring_vec_t v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += int'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/ring_decoder_onehot_enc.sv
// Combinational one-hot to binary encoder; the index is only meaningful
// when onehot is set.
module onehot_enc
  import ring_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [POS_W-1:0] idx,
  output logic             onehot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) begin
        idx = idx | POS_W'(i);
      end
    end
    onehot = is_onehot(ring_vec_t'(in_vec));
  end

endmodule

// File: rtl/ring_decoder.sv
// Monitors a one-hot ring counter bus: decodes position, checks one-step
// advances, locks after LOCK_CNT good advances, counts revolutions and breaks.
module ring_decoder
  import ring_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 2,
  parameter  int CNT_W    = 8,
  localparam int POS_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring_in,
  output logic [POS_W-1:0] pos,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] rev_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int OK_W = $clog2(LOCK_CNT + 1);

  ring_state_t      state_q, state_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic             in_v_q, in_v_d;
  logic [OK_W-1:0]  ok_cnt_q, ok_cnt_d, ok_inc;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rev_q, rev_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  logic [POS_W-1:0] enc_idx;
  logic             oh;
  logic             adv_ok;

  onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .in_vec (ring_in),
    .idx    (enc_idx),
    .onehot (oh)
  );

  always_comb begin
    adv_ok   = oh && in_v_q && (ring_vec_t'(ring_in) == rotl1(ring_vec_t'(in_q), WIDTH));
    ok_inc   = ok_cnt_q + OK_W'(1);

    in_d     = ring_in;
    in_v_d   = oh;
    pos_d    = oh ? enc_idx : pos_q;
    valid_d  = oh;
    state_d  = state_q;
    ok_cnt_d = ok_cnt_q;
    err_d    = 1'b0;
    rev_d    = rev_q;
    errc_d   = errc_q;

    case (state_q)
      HUNT: begin
        if (adv_ok) begin
          if (ok_inc == OK_W'(LOCK_CNT)) begin
            state_d  = LOCKED;
            ok_cnt_d = '0;
          end else begin
            ok_cnt_d = ok_inc;
          end
        end else begin
          ok_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (adv_ok) begin
          // Landing on bit 0 means the MSB just wrapped: one full revolution.
          if (ring_in[0]) begin
            rev_d = rev_q + CNT_W'(1);
          end
        end else begin
          state_d  = HUNT;
          err_d    = 1'b1;
          ok_cnt_d = '0;
          if (errc_q != '1) begin
            errc_d = errc_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d  = HUNT;
        ok_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      in_q     <= '0;
      in_v_q   <= 1'b0;
      ok_cnt_q <= '0;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rev_q    <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      in_v_q   <= in_v_d;
      ok_cnt_q <= ok_cnt_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      rev_q    <= rev_d;
      errc_q   <= errc_d;
    end
  end

  assign pos       = pos_q;
  assign valid     = valid_q;
  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign rev_count = rev_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder: a default-width instance and a CNT_W=2
// instance share the same stimulus; expected values are hand-derived.
module tb_ring_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] ring_in;

  logic [1:0] pos, pos2;
  logic       valid, valid2, locked, locked2, err, err2;
  logic [7:0] rev_count, err_count;
  logic [1:0] rev_count2, err_count2;

  int n_checks = 0;
  int n_errors = 0;

  ring_decoder #(.WIDTH(4), .LOCK_CNT(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in),
    .pos       (pos),
    .valid     (valid),
    .locked    (locked),
    .err       (err),
    .rev_count (rev_count),
    .err_count (err_count)
  );

  ring_decoder #(.WIDTH(4), .LOCK_CNT(2), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in),
    .pos       (pos2),
    .valid     (valid2),
    .locked    (locked2),
    .err       (err2),
    .rev_count (rev_count2),
    .err_count (err_count2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: present one sample, let it be clocked in, settle past the edge
  task automatic step(input logic [3:0] v, input logic r);
    @(negedge clk);
    ring_in = v;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos"},   32'(pos),       0);
    check({tag, "_valid"}, 32'(valid),     0);
    check({tag, "_lock"},  32'(locked),    0);
    check({tag, "_err"},   32'(err),       0);
    check({tag, "_rev"},   32'(rev_count), 0);
    check({tag, "_errc"},  32'(err_count), 0);
  endtask

  logic [3:0] cur;

  initial begin
    ring_in = 4'b0000;
    rst     = 1'b1;

    // reset and clean ring
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check_all_zero("reset");

    step(4'b0001, 1'b0);
    check("s1_valid", 32'(valid), 1);
    check("s1_pos",   32'(pos),   0);
    check("s1_lock",  32'(locked), 0);
    step(4'b0010, 1'b0);
    check("s2_pos",   32'(pos),   1);
    check("s2_lock",  32'(locked), 0);
    step(4'b0100, 1'b0);
    check("s3_pos",   32'(pos),   2);
    check("s3_lock",  32'(locked), 1);
    step(4'b1000, 1'b0);
    check("s4_pos",   32'(pos),   3);
    check("s4_rev",   32'(rev_count), 0);
    step(4'b0001, 1'b0);
    check("s5_pos",   32'(pos),   0);
    check("s5_rev",   32'(rev_count), 1);

    // hold error
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    check("hold_pre_err", 32'(err), 0);
    step(4'b0100, 1'b0);
    check("hold_err",  32'(err),       1);
    check("hold_lock", 32'(locked),    0);
    check("hold_errc", 32'(err_count), 1);
    step(4'b1000, 1'b0);
    check("hold_err_pulse", 32'(err), 0);
    check("hold_relock1",   32'(locked), 0);
    step(4'b0001, 1'b0);
    check("hold_relock2",   32'(locked), 1);
    check("hold_rev_nowrap", 32'(rev_count), 1);

    // invalid inputs while locked
    step(4'b0010, 1'b0);
    check("inv_pre_pos", 32'(pos), 1);
    step(4'b0110, 1'b0);
    check("inv_mh_valid", 32'(valid),     0);
    check("inv_mh_pos",   32'(pos),       1);
    check("inv_mh_err",   32'(err),       1);
    check("inv_mh_errc",  32'(err_count), 2);
    check("inv_mh_lock",  32'(locked),    0);
    step(4'b0000, 1'b0);
    check("inv_z_valid", 32'(valid),     0);
    check("inv_z_pos",   32'(pos),       1);
    check("inv_z_err",   32'(err),       0);
    check("inv_z_errc",  32'(err_count), 2);

    // relock from an invalid previous sample needs a fresh first sample
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    check("rl_lock_a", 32'(locked), 0);
    step(4'b0100, 1'b0);
    check("rl_lock_b", 32'(locked), 1);

    // reverse step
    step(4'b0010, 1'b0);
    check("rev_err",  32'(err),       1);
    check("rev_errc", 32'(err_count), 3);
    check("rev_lock", 32'(locked),    0);
    check("rev_revc", 32'(rev_count), 1);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    check("rev_relock", 32'(locked), 1);
    // skip: 0001 is a legal wrap (counted), then 0100 skips 0010
    step(4'b0001, 1'b0);
    check("skip_wrap_rev", 32'(rev_count), 2);
    step(4'b0100, 1'b0);
    check("skip_err",  32'(err),       1);
    check("skip_errc", 32'(err_count), 4);
    check("skip_revc", 32'(rev_count), 2);

    // reset mid-run
    step(4'b1000, 1'b1);
    check_all_zero("midrst");
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    check("midrst_lock_a", 32'(locked), 0);
    step(4'b0100, 1'b0);
    check("midrst_lock_b", 32'(locked), 1);

    // counter limits: 5 revolutions then 5 errors on both instances
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    check("lim_lock", 32'(locked2), 1);
    step(4'b1000, 1'b0);
    step(4'b0001, 1'b0);
    for (int r = 0; r < 4; r++) begin
      step(4'b0010, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b0001, 1'b0);
    end
    check("lim_rev8", 32'(rev_count),  5);
    check("lim_rev2", 32'(rev_count2), 1);
    cur = 4'b0001;
    for (int e = 0; e < 5; e++) begin
      step(cur, 1'b0);                         // held sample: error
      check($sformatf("lim_err_pulse%0d", e), 32'(err2), 1);
      cur = {cur[2:0], cur[3]};
      step(cur, 1'b0);
      cur = {cur[2:0], cur[3]};
      step(cur, 1'b0);                         // relocked on this sample
    end
    check("lim_errc8", 32'(err_count),  5);
    check("lim_errc2", 32'(err_count2), 3);
    check("lim_rev2_hold", 32'(rev_count2), 1);
    check("lim_relock", 32'(locked2), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
